// File: rtl/mux4_rr_arbiter_if.sv
// Handshake/data bundle between the four requesters and the mux arbiter.
// The master modport belongs to the arbiter; the slave modport belongs to the requester side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       valid;

  modport master (
    input  req,
    input  din,
    output gnt,
    output sel,
    output y,
    output valid
  );

  modport slave (
    output req,
    output din,
    input  gnt,
    input  sel,
    input  y,
    input  valid
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux among four requesters, with bounded tenure.
// Define MUX4_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux4_rr_arbiter_if.master bus
);

  localparam int unsigned      HoldEff = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HoldEff);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [3:0]       gnt_q;
  logic [1:0]       sel_q;
  logic             y_q;
  logic             valid_q;
`ifndef MUX4_ARB_FIXED_PRIO_EN
  logic [1:0]       last_q;
`endif

  logic       win_found;
  logic [1:0] win_idx;
  logic       release_now;

  assign release_now = (state_q == StBusy) && (!bus.req[sel_q] || (hold_cnt_q == HoldMax));

`ifdef MUX4_ARB_FIXED_PRIO_EN
  logic [3:0] cand;

  // Other pending requesters outrank the holder; the holder is regranted only when alone.
  always_comb begin
    cand      = bus.req;
    win_found = 1'b0;
    win_idx   = 2'd0;
    if ((state_q == StBusy) && ((bus.req & ~gnt_q) != 4'b0000)) begin
      cand = bus.req & ~gnt_q;
    end
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
  end
`else
  // Search last+1, last+2, last+3, last; while busy last equals sel, so the holder comes last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      if (bus.req[2'(last_q + 2'(i))]) begin
        win_found = 1'b1;
        win_idx   = 2'(last_q + 2'(i));
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      y_q        <= 1'b0;
      valid_q    <= 1'b0;
`ifndef MUX4_ARB_FIXED_PRIO_EN
      last_q     <= 2'd3;
`endif
    end else begin
      valid_q <= (gnt_q != 4'b0000);
      if (gnt_q != 4'b0000) begin
        y_q <= bus.din[sel_q];
      end

      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q    <= StBusy;
            gnt_q      <= 4'b0001 << win_idx;
            sel_q      <= win_idx;
            hold_cnt_q <= CNT_W'(1);
`ifndef MUX4_ARB_FIXED_PRIO_EN
            last_q     <= win_idx;
`endif
          end
        end
        StBusy: begin
          if (!release_now) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end else if (win_found) begin
            gnt_q      <= 4'b0001 << win_idx;
            sel_q      <= win_idx;
            hold_cnt_q <= CNT_W'(1);
`ifndef MUX4_ARB_FIXED_PRIO_EN
            last_q     <= win_idx;
`endif
          end else begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.y     = y_q;
  assign bus.valid = valid_q;

endmodule
